// File: rtl/axil_gpio_bram_slave.sv
// AXI4-Lite slave decoding to an 8-bit LED register bank (addr MSB = 0) and a word-addressed scratch RAM (addr MSB = 1).
// Optional feature: define AXIL_SLVERR_EN to answer unmapped register offsets with SLVERR.
module axil_gpio_bram_slave #(
   parameter int          ADDR_WIDTH = 12,
   parameter int          RAM_WORDS  = 256,
   parameter logic [7:0]  LED_RESET  = 8'h00,
   parameter logic [31:0] ID_VALUE   = 32'h4D50_5343
) (
   input  logic                  s_axi_aclk,
   input  logic                  s_axi_areset,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [31:0]           s_axi_wdata,
   input  logic [3:0]            s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [7:0]            leds
);
   localparam int IDX_W = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int OFF_W = ADDR_WIDTH - 3;
   localparam logic [1:0]       RESP_OKAY      = 2'b00;
   localparam logic [1:0]       RESP_SLVERR    = 2'b10;
   localparam logic [OFF_W-1:0] OFF_LED_DATA   = OFF_W'(2'd0);
   localparam logic [OFF_W-1:0] OFF_LED_TOGGLE = OFF_W'(2'd1);
   localparam logic [OFF_W-1:0] OFF_ID         = OFF_W'(2'd2);
`ifdef AXIL_SLVERR_EN
   localparam bit SLVERR_EN = 1'b1;
`else
   localparam bit SLVERR_EN = 1'b0;
`endif

   typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rstate_t;

   function automatic logic [1:0] f_resp(input logic is_ram, input logic [OFF_W-1:0] off);
      return (SLVERR_EN && !is_ram && (off > OFF_ID)) ? RESP_SLVERR : RESP_OKAY;
   endfunction

   wstate_t               r_wstate;
   rstate_t               r_rstate;
   logic                  r_awready, r_wready, r_arready;
   logic                  r_aw_held, r_w_held;
   logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wstrb;
   logic                  r_bvalid, r_rvalid;
   logic [1:0]            r_bresp, r_rresp;
   logic [31:0]           r_rdata;
   logic [7:0]            r_leds;
   logic [31:0]           r_mem [RAM_WORDS];

   logic                  w_aw_hs, w_w_hs, w_commit, w_ram_we;
   logic [ADDR_WIDTH-1:0] w_awaddr;
   logic [31:0]           w_wdata;
   logic [3:0]            w_wstrb;
   logic                  w_wr_ram, w_rd_ram;
   logic [OFF_W-1:0]      w_wr_off, w_rd_off;
   logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;
   logic [31:0]           w_reg_rdata;
   logic                  w_unused_addr_bits;

   // Merge held and live channel beats so the write commits in the later handshake cycle
   always_comb begin
      w_aw_hs  = s_axi_awvalid & r_awready;
      w_w_hs   = s_axi_wvalid & r_wready;
      w_awaddr = r_aw_held ? r_awaddr : s_axi_awaddr;
      w_wdata  = r_w_held ? r_wdata : s_axi_wdata;
      w_wstrb  = r_w_held ? r_wstrb : s_axi_wstrb;
      w_commit = !s_axi_areset && (r_wstate == W_IDLE) &&
                 (r_aw_held | w_aw_hs) && (r_w_held | w_w_hs);
      w_wr_ram = w_awaddr[ADDR_WIDTH-1];
      w_wr_off = w_awaddr[ADDR_WIDTH-2:2];
      w_wr_idx = w_awaddr[IDX_W+1:2];
      w_ram_we = w_commit & w_wr_ram;
      w_rd_ram = r_araddr[ADDR_WIDTH-1];
      w_rd_off = r_araddr[ADDR_WIDTH-2:2];
      w_rd_idx = r_araddr[IDX_W+1:2];
   end

   // Register-bank read mux
   always_comb begin
      case (w_rd_off)
         OFF_LED_DATA: w_reg_rdata = {24'h00_0000, r_leds};
         OFF_ID:       w_reg_rdata = ID_VALUE;
         default:      w_reg_rdata = 32'h0000_0000;
      endcase
   end

   assign w_unused_addr_bits = ^{w_awaddr[1:0], r_araddr[1:0]};

   // Byte-enabled RAM write port; contents are deliberately left unreset
   always_ff @(posedge s_axi_aclk) begin
      for (int b = 0; b < 4; b++) begin
         if (w_ram_we && w_wstrb[b]) begin
            r_mem[w_wr_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
         end
      end
   end

   // Write FSM: independent AW/W capture, commit, then B response
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= 32'h0000_0000;
         r_wstrb   <= 4'h0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_leds    <= LED_RESET;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (w_commit) begin
                  r_awready <= 1'b0;
                  r_wready  <= 1'b0;
                  r_aw_held <= 1'b0;
                  r_w_held  <= 1'b0;
                  r_bvalid  <= 1'b1;
                  r_bresp   <= f_resp(w_wr_ram, w_wr_off);
                  r_wstate  <= W_RESP;
                  if (!w_wr_ram && w_wstrb[0] && (w_wr_off == OFF_LED_DATA)) begin
                     r_leds <= w_wdata[7:0];
                  end else if (!w_wr_ram && w_wstrb[0] && (w_wr_off == OFF_LED_TOGGLE)) begin
                     r_leds <= r_leds ^ w_wdata[7:0];
                  end
               end else begin
                  if (w_aw_hs) begin
                     r_aw_held <= 1'b1;
                     r_awaddr  <= s_axi_awaddr;
                     r_awready <= 1'b0;
                  end else if (!r_aw_held) begin
                     r_awready <= 1'b1;
                  end
                  if (w_w_hs) begin
                     r_w_held <= 1'b1;
                     r_wdata  <= s_axi_wdata;
                     r_wstrb  <= s_axi_wstrb;
                     r_wready <= 1'b0;
                  end else if (!r_w_held) begin
                     r_wready <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
                  r_wstate  <= W_IDLE;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   // Read FSM: latch address, one fetch cycle, then hold R until accepted
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_araddr  <= '0;
         r_rvalid  <= 1'b0;
         r_rresp   <= RESP_OKAY;
         r_rdata   <= 32'h0000_0000;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (s_axi_arvalid && r_arready) begin
                  r_araddr  <= s_axi_araddr;
                  r_arready <= 1'b0;
                  r_rstate  <= R_FETCH;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            R_FETCH: begin
               r_rdata  <= w_rd_ram ? r_mem[w_rd_idx] : w_reg_rdata;
               r_rresp  <= f_resp(w_rd_ram, w_rd_off);
               r_rvalid <= 1'b1;
               r_rstate <= R_DATA;
            end
            R_DATA: begin
               if (s_axi_rready) begin
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
                  r_rstate  <= R_IDLE;
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   assign s_axi_awready = r_awready;
   assign s_axi_wready  = r_wready;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_arready = r_arready;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rresp   = r_rresp;
   assign s_axi_rdata   = r_rdata;
   assign leds          = r_leds;
endmodule
